// File: rtl/enc8b10b_pkg.sv
// 8b/10b code tables and disparity helpers shared by the encoder stage.
// Pure functions and constants; no timing or flow-control behaviour.
package enc8b10b_pkg;

    localparam logic [4:0] K28_X   = 5'd28;
    localparam logic [2:0] K28_5_Y = 3'd5;
    localparam logic [5:0] K28_6B  = 6'b001111;
    localparam logic [3:0] A7_4B   = 4'b0111;

    // {complement-for-RD+, abcdei for RD-}; D.7 is balanced yet still flips.
    function automatic logic [6:0] tab5b6b(input logic [4:0] x);
        case (x)
            5'd0:    tab5b6b = {1'b1, 6'b100111};
            5'd1:    tab5b6b = {1'b1, 6'b011101};
            5'd2:    tab5b6b = {1'b1, 6'b101101};
            5'd3:    tab5b6b = {1'b0, 6'b110001};
            5'd4:    tab5b6b = {1'b1, 6'b110101};
            5'd5:    tab5b6b = {1'b0, 6'b101001};
            5'd6:    tab5b6b = {1'b0, 6'b011001};
            5'd7:    tab5b6b = {1'b1, 6'b111000};
            5'd8:    tab5b6b = {1'b1, 6'b111001};
            5'd9:    tab5b6b = {1'b0, 6'b100101};
            5'd10:   tab5b6b = {1'b0, 6'b010101};
            5'd11:   tab5b6b = {1'b0, 6'b110100};
            5'd12:   tab5b6b = {1'b0, 6'b001101};
            5'd13:   tab5b6b = {1'b0, 6'b101100};
            5'd14:   tab5b6b = {1'b0, 6'b011100};
            5'd15:   tab5b6b = {1'b1, 6'b010111};
            5'd16:   tab5b6b = {1'b1, 6'b011011};
            5'd17:   tab5b6b = {1'b0, 6'b100011};
            5'd18:   tab5b6b = {1'b0, 6'b010011};
            5'd19:   tab5b6b = {1'b0, 6'b110010};
            5'd20:   tab5b6b = {1'b0, 6'b001011};
            5'd21:   tab5b6b = {1'b0, 6'b101010};
            5'd22:   tab5b6b = {1'b0, 6'b011010};
            5'd23:   tab5b6b = {1'b1, 6'b111010};
            5'd24:   tab5b6b = {1'b1, 6'b110011};
            5'd25:   tab5b6b = {1'b0, 6'b100110};
            5'd26:   tab5b6b = {1'b0, 6'b010110};
            5'd27:   tab5b6b = {1'b1, 6'b110110};
            5'd28:   tab5b6b = {1'b0, 6'b001110};
            5'd29:   tab5b6b = {1'b1, 6'b101110};
            5'd30:   tab5b6b = {1'b1, 6'b011110};
            default: tab5b6b = {1'b1, 6'b101011};
        endcase
    endfunction

    // {complement-for-RD+, fghj for RD-}; entry 7 is the primary P7 code.
    function automatic logic [4:0] tab3b4b(input logic [2:0] y);
        case (y)
            3'd0:    tab3b4b = {1'b1, 4'b1011};
            3'd1:    tab3b4b = {1'b0, 4'b1001};
            3'd2:    tab3b4b = {1'b0, 4'b0101};
            3'd3:    tab3b4b = {1'b1, 4'b1100};
            3'd4:    tab3b4b = {1'b1, 4'b1101};
            3'd5:    tab3b4b = {1'b0, 4'b1010};
            3'd6:    tab3b4b = {1'b0, 4'b0110};
            default: tab3b4b = {1'b1, 4'b1110};
        endcase
    endfunction

    function automatic logic k_legal(input logic [4:0] x, input logic [2:0] y);
        k_legal = (x == K28_X) ||
                  ((y == 3'd7) && (x == 5'd23 || x == 5'd27 || x == 5'd29 || x == 5'd30));
    endfunction

    function automatic logic unbal6(input logic [5:0] w);
        int n;
        n = 0;
        for (int i = 0; i < 6; i++) n += int'(w[i]);
        unbal6 = (n != 3);
    endfunction

    function automatic logic signed [4:0] disp10(input logic [9:0] w);
        int n;
        n = 0;
        for (int i = 0; i < 10; i++) n += int'(w[i]);
        disp10 = 5'(2 * n - 10);
    endfunction

endpackage

// File: rtl/enc8b10b_core.sv
// Combinational 8b/10b encode of one 9-bit K/data word at a given running disparity.
// Zero latency, no flow control; illegal K requests are replaced by K28.5.
module enc8b10b_core
    import enc8b10b_pkg::*;
(
    input  logic [8:0] i_data,
    input  logic       i_rd,
    output logic [9:0] o_code,
    output logic       o_rd_next,
    output logic       o_kerr
);

    logic       w_k, w_bad, w_k28, w_cmp6, w_rd6, w_use_a7, w_cmp4;
    logic [4:0] w_x;
    logic [2:0] w_y;
    logic [6:0] w_e6;
    logic [4:0] w_e4;
    logic [5:0] w_base6, w_six;
    logic [3:0] w_base4, w_p4, w_four;

    always_comb begin
        w_k   = i_data[8];
        w_bad = w_k & ~k_legal(i_data[4:0], i_data[7:5]);
        w_x   = w_bad ? K28_X : i_data[4:0];
        w_y   = w_bad ? K28_5_Y : i_data[7:5];
        w_k28 = w_k & (w_x == K28_X);

        w_e6    = tab5b6b(w_x);
        w_base6 = w_k28 ? K28_6B : w_e6[5:0];
        w_cmp6  = w_k28 | w_e6[6];
        w_six   = (i_rd & w_cmp6) ? ~w_base6 : w_base6;
        w_rd6   = i_rd ^ unbal6(w_six);

        // Alternate A7 avoids a run of five identical bits across the 6b/4b boundary.
        w_use_a7 = (w_y == 3'd7) &
                   (w_k |
                    (~w_rd6 & (w_x == 5'd17 || w_x == 5'd18 || w_x == 5'd20)) |
                    ( w_rd6 & (w_x == 5'd11 || w_x == 5'd13 || w_x == 5'd14)));
        w_e4    = tab3b4b(w_y);
        w_base4 = w_use_a7 ? A7_4B : w_e4[3:0];
        w_cmp4  = w_use_a7 | w_e4[4];
        w_p4    = w_cmp4 ? ~w_base4 : w_base4;

        // K28 fghj is the bitwise inverse of the data code when rd6 is negative.
        if (w_k28)
            w_four = w_rd6 ? w_p4 : ~w_p4;
        else
            w_four = w_rd6 ? w_p4 : w_base4;

        o_code    = {w_six, w_four};
        o_rd_next = i_rd ^ (disp10(o_code) != 5'sd0);
        o_kerr    = w_bad;
    end

endmodule

// File: rtl/enc8b10b_stage.sv
// Registered 8b/10b encoder stage with running disparity and resync; 1 clk latency.
// No backpressure: every push is encoded and emitted on the following cycle.
module enc8b10b_stage
    import enc8b10b_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       startin,
    input  logic       pushin,
    input  logic [8:0] datain,
    output logic [9:0] dataout,
    output logic       pushout,
    output logic       rdout,
    output logic       kerr
);

    logic       r_rd, r_pushout, r_kerr;
    logic [9:0] r_dataout;
    logic       w_rd_in, w_rd_next, w_kerr;
    logic [9:0] w_code;

    // A same-cycle resync makes the pushed word start from RD-.
    assign w_rd_in = startin ? 1'b0 : r_rd;

    enc8b10b_core u_core (
        .i_data    (datain),
        .i_rd      (w_rd_in),
        .o_code    (w_code),
        .o_rd_next (w_rd_next),
        .o_kerr    (w_kerr)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd      <= 1'b0;
            r_pushout <= 1'b0;
            r_kerr    <= 1'b0;
            r_dataout <= 10'h000;
        end else begin
            r_pushout <= pushin;
            r_kerr    <= pushin & w_kerr;
            if (pushin) begin
                r_dataout <= w_code;
                r_rd      <= w_rd_next;
            end else if (startin) begin
                r_rd      <= 1'b0;
            end
        end
    end

    assign dataout = r_dataout;
    assign pushout = r_pushout;
    assign rdout   = r_rd;
    assign kerr    = r_kerr;

endmodule
